// File: rtl/enigma_keystroke_sequencer.sv
// Keystroke sequencer for the Enigma signal path: owns the rotor positions,
// applies historical stepping, drives the key through the path and holds the lamp.
module enigma_keystroke_sequencer #(
    parameter int R_NOTCH       = 21,
    parameter int M_NOTCH       = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [4:0]  load_pos_l,
    input  logic [4:0]  load_pos_m,
    input  logic [4:0]  load_pos_r,
    input  logic        key_valid,
    input  logic [25:0] key_in,
    output logic        key_ready,
    output logic [4:0]  pos_l,
    output logic [4:0]  pos_m,
    output logic [4:0]  pos_r,
    output logic [25:0] path_in,
    input  logic [25:0] path_out,
    output logic [25:0] lamp_out,
    output logic        lamp_valid,
    input  logic        lamp_ack,
    output logic        error
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STEP   = 2'd1,
        SETTLE = 2'd2,
        SHOW   = 2'd3
    } state_t;

    localparam logic [4:0] R_NOTCH_P   = 5'(R_NOTCH);
    localparam logic [4:0] M_NOTCH_P   = 5'(M_NOTCH);
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    function automatic logic is_onehot(input logic [25:0] v);
        return (v != 26'd0) && ((v & (v - 26'd1)) == 26'd0);
    endfunction

    function automatic logic [4:0] inc26(input logic [4:0] p);
        return (p == 5'd25) ? 5'd0 : p + 5'd1;
    endfunction

    state_t      state_r, state_s;
    logic [4:0]  pos_l_r, pos_m_r, pos_r_r;
    logic [4:0]  pos_l_s, pos_m_s, pos_r_s;
    logic [25:0] key_r, key_s;
    logic [3:0]  cnt_r, cnt_s;
    logic [25:0] path_in_r, path_in_s;
    logic [25:0] lamp_r, lamp_s;
    logic        lamp_valid_r, lamp_valid_s;
    logic        error_r, error_s;
    logic        key_ready_s;
    logic        load_legal_s;
    logic        sample_s;

    assign load_legal_s = (load_pos_l <= 5'd25) && (load_pos_m <= 5'd25) && (load_pos_r <= 5'd25);
    assign sample_s     = (cnt_r == SETTLE_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (!load && key_valid && is_onehot(key_in)) begin
                    state_s = STEP;
                end else begin
                    state_s = IDLE;
                end
            end
            STEP: state_s = SETTLE;
            SETTLE: begin
                if (sample_s) begin
                    state_s = SHOW;
                end else begin
                    state_s = SETTLE;
                end
            end
            SHOW: begin
                if (lamp_ack) begin
                    state_s = IDLE;
                end else begin
                    state_s = SHOW;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Next values of the datapath registers and outputs
    always_comb begin
        pos_l_s      = pos_l_r;
        pos_m_s      = pos_m_r;
        pos_r_s      = pos_r_r;
        key_s        = key_r;
        cnt_s        = cnt_r;
        path_in_s    = 26'd0;
        lamp_s       = lamp_r;
        lamp_valid_s = 1'b0;
        error_s      = 1'b0;
        key_ready_s  = 1'b0;
        case (state_r)
            IDLE: begin
                key_ready_s = ~load;
                if (load) begin
                    if (load_legal_s) begin
                        pos_l_s = load_pos_l;
                        pos_m_s = load_pos_m;
                        pos_r_s = load_pos_r;
                    end else begin
                        error_s = 1'b1;
                    end
                end else if (key_valid) begin
                    if (is_onehot(key_in)) begin
                        key_s = key_in;
                    end else begin
                        error_s = 1'b1;
                    end
                end else begin
                    key_s = key_r;
                end
            end
            STEP: begin
                // Middle notch steps both middle and left rotors (double step)
                pos_r_s = inc26(pos_r_r);
                if ((pos_r_r == R_NOTCH_P) || (pos_m_r == M_NOTCH_P)) begin
                    pos_m_s = inc26(pos_m_r);
                end else begin
                    pos_m_s = pos_m_r;
                end
                if (pos_m_r == M_NOTCH_P) begin
                    pos_l_s = inc26(pos_l_r);
                end else begin
                    pos_l_s = pos_l_r;
                end
                cnt_s     = 4'd0;
                path_in_s = key_r;
            end
            SETTLE: begin
                if (sample_s) begin
                    if (is_onehot(path_out)) begin
                        lamp_s = path_out;
                    end else begin
                        lamp_s  = 26'd0;
                        error_s = 1'b1;
                    end
                    lamp_valid_s = 1'b1;
                end else begin
                    cnt_s     = cnt_r + 4'd1;
                    path_in_s = key_r;
                end
            end
            SHOW: lamp_valid_s = ~lamp_ack;
            default: lamp_valid_s = 1'b0;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            pos_l_r      <= 5'd0;
            pos_m_r      <= 5'd0;
            pos_r_r      <= 5'd0;
            key_r        <= 26'd0;
            cnt_r        <= 4'd0;
            path_in_r    <= 26'd0;
            lamp_r       <= 26'd0;
            lamp_valid_r <= 1'b0;
            error_r      <= 1'b0;
        end else begin
            pos_l_r      <= pos_l_s;
            pos_m_r      <= pos_m_s;
            pos_r_r      <= pos_r_s;
            key_r        <= key_s;
            cnt_r        <= cnt_s;
            path_in_r    <= path_in_s;
            lamp_r       <= lamp_s;
            lamp_valid_r <= lamp_valid_s;
            error_r      <= error_s;
        end
    end

    assign key_ready  = key_ready_s;
    assign pos_l      = pos_l_r;
    assign pos_m      = pos_m_r;
    assign pos_r      = pos_r_r;
    assign path_in    = path_in_r;
    assign lamp_out   = lamp_r;
    assign lamp_valid = lamp_valid_r;
    assign error      = error_r;

endmodule
